// File: rtl/dca_adder_share_scheduler_if.sv
// Bundles the requester handshake and the shared-adder control/result bus.
// The master modport is the scheduler's view; slave is the surrounding environment.
interface dca_adder_share_scheduler_if #(
    parameter int NUM_REQ          = 4,
    parameter int BW_TENSOR_SCALAR = 32
);
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [NUM_REQ-1:0]                  req_is_sub;
    logic [NUM_REQ-1:0]                  req_is_float;
    logic [NUM_REQ*BW_TENSOR_SCALAR-1:0] req_input0;
    logic [NUM_REQ*BW_TENSOR_SCALAR-1:0] req_input1;
    logic [NUM_REQ-1:0]                  rsp_valid;
    logic [NUM_REQ-1:0]                  rsp_ready;
    logic [BW_TENSOR_SCALAR-1:0]         rsp_result;
    logic                                add_enable;
    logic                                add_is_sub;
    logic                                add_is_float;
    logic                                add_in_valid;
    logic [BW_TENSOR_SCALAR-1:0]         add_in0;
    logic [BW_TENSOR_SCALAR-1:0]         add_in1;
    logic                                add_out_valid;
    logic [BW_TENSOR_SCALAR-1:0]         add_out_result;

    modport master (
        input  req_valid, req_is_sub, req_is_float, req_input0, req_input1,
        input  rsp_ready, add_out_valid, add_out_result,
        output req_ready, rsp_valid, rsp_result,
        output add_enable, add_is_sub, add_is_float, add_in_valid, add_in0, add_in1
    );

    modport slave (
        output req_valid, req_is_sub, req_is_float, req_input0, req_input1,
        output rsp_ready, add_out_valid, add_out_result,
        input  req_ready, rsp_valid, rsp_result,
        input  add_enable, add_is_sub, add_is_float, add_in_valid, add_in0, add_in1
    );
endinterface

// File: rtl/dca_adder_share_scheduler.sv
// Round-robin issue scheduler sharing one add/sub unit among NUM_REQ requesters,
// with a tag pipeline routing float results back and an enable-based stall.
module dca_adder_share_scheduler #(
    parameter int NUM_REQ          = 4,
    parameter int BW_TENSOR_SCALAR = 32,
    parameter int FLOAT_LATENCY    = 3
) (
    input  logic                            clk,
    input  logic                            rstnn,
    dca_adder_share_scheduler_if.master     bus,
    output logic                            busy,
    output logic                            err_orphan
);
    localparam int BW  = BW_TENSOR_SCALAR;
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(FLOAT_LATENCY + 1);
    localparam int HD  = FLOAT_LATENCY - 1;

    logic [FLOAT_LATENCY-1:0] tag_v_q, tag_v_d;
    logic [IDW-1:0]           tag_id_q [FLOAT_LATENCY];
    logic [IDW-1:0]           tag_id_d [FLOAT_LATENCY];
    logic [IDW-1:0]           rr_ptr_q, rr_ptr_d;
    logic                     mode_q, mode_d;
    logic                     err_orphan_q, err_orphan_d;

    logic                     head_v_s;
    logic [IDW-1:0]           head_id_s;
    logic                     enable_s;
    logic [CW-1:0]            inflight_s;
    logic                     win_found_s;
    logic [IDW-1:0]           win_id_s;
    logic                     win_float_s;
    logic                     issue_s;
    logic                     is_float_s;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        s = (s >= NUM_REQ) ? (s - NUM_REQ) : s;
        return IDW'(s);
    endfunction

    // Stall, occupancy and round-robin winner selection; scanning downward lets the nearest requester win.
    always_comb begin
        head_v_s   = tag_v_q[HD];
        head_id_s  = tag_id_q[HD];
        enable_s   = !(head_v_s && !bus.rsp_ready[head_id_s]);
        inflight_s = '0;
        for (int i = 0; i < FLOAT_LATENCY; i++) begin
            inflight_s = inflight_s + CW'(tag_v_q[i]);
        end
        win_found_s = 1'b0;
        win_id_s    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            win_found_s = win_found_s | bus.req_valid[wrap_add(rr_ptr_q, k)];
            win_id_s    = bus.req_valid[wrap_add(rr_ptr_q, k)] ? wrap_add(rr_ptr_q, k) : win_id_s;
        end
        win_float_s = bus.req_is_float[win_id_s];
        if (!rstnn || !win_found_s) begin
            issue_s = 1'b0;
        end else if (win_float_s) begin
            issue_s = enable_s;
        end else begin
            // Integer results share the output mux, so wait for an empty float pipe.
            issue_s = (inflight_s == '0) && bus.rsp_ready[win_id_s];
        end
        is_float_s = rstnn && (issue_s ? win_float_s : mode_q);
    end

    // Grant, adder drive and response routing.
    always_comb begin
        bus.req_ready    = '0;
        bus.rsp_valid    = '0;
        bus.add_in_valid = issue_s;
        bus.add_is_float = is_float_s;
        bus.add_enable   = !rstnn || enable_s;
        bus.rsp_result   = bus.add_out_result;
        if (issue_s) begin
            bus.req_ready[win_id_s] = 1'b1;
            bus.add_is_sub = bus.req_is_sub[win_id_s];
            bus.add_in0    = bus.req_input0[win_id_s*BW +: BW];
            bus.add_in1    = bus.req_input1[win_id_s*BW +: BW];
        end else begin
            bus.add_is_sub = 1'b0;
            bus.add_in0    = '0;
            bus.add_in1    = '0;
        end
        if (issue_s && !win_float_s) begin
            bus.rsp_valid[win_id_s] = 1'b1;
        end else if (rstnn && head_v_s && bus.add_out_valid) begin
            bus.rsp_valid[head_id_s] = 1'b1;
        end else begin
            bus.rsp_valid = '0;
        end
        busy       = rstnn && (inflight_s != '0);
        err_orphan = err_orphan_q;
    end

    // Next state: the tag pipe advances in lockstep with the adder enable.
    always_comb begin
        tag_v_d  = tag_v_q;
        tag_id_d = tag_id_q;
        if (enable_s) begin
            for (int i = HD; i >= 1; i--) begin
                tag_v_d[i]  = tag_v_q[i-1];
                tag_id_d[i] = tag_id_q[i-1];
            end
            tag_v_d[0]  = issue_s && win_float_s;
            tag_id_d[0] = win_id_s;
        end else begin
            tag_v_d = tag_v_q;
        end
        if (issue_s) begin
            rr_ptr_d = (win_id_s == IDW'(NUM_REQ - 1)) ? '0 : (win_id_s + IDW'(1));
            mode_d   = win_float_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
            mode_d   = mode_q;
        end
        err_orphan_d = err_orphan_q | (is_float_s && bus.add_out_valid && !head_v_s);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            tag_v_q      <= '0;
            for (int i = 0; i < FLOAT_LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
            rr_ptr_q     <= '0;
            mode_q       <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            tag_v_q      <= tag_v_d;
            tag_id_q     <= tag_id_d;
            rr_ptr_q     <= rr_ptr_d;
            mode_q       <= mode_d;
            err_orphan_q <= err_orphan_d;
        end
    end
endmodule

// File: tb/tb_dca_adder_share_scheduler.sv
// Bench for dca_adder_share_scheduler: a behavioural adder plus a queue-based
// reference of the scheduling rules, a vector table, directed corners and random traffic.
module tb_dca_adder_share_scheduler;
    localparam int N  = 4;
    localparam int BW = 32;
    localparam int FL = 3;

    logic clk, rstnn, busy, err_orphan, inj;
    int   total, bad, cyc;

    dca_adder_share_scheduler_if #(.NUM_REQ(N), .BW_TENSOR_SCALAR(BW)) bus ();

    dca_adder_share_scheduler #(.NUM_REQ(N), .BW_TENSOR_SCALAR(BW), .FLOAT_LATENCY(FL)) dut (
        .clk(clk), .rstnn(rstnn), .bus(bus), .busy(busy), .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-precision helpers via double arithmetic (normal numbers only, truncating).
    function automatic real sp2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) return 0.0;
        d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e < 11'd897) return {d[63], 31'd0};
        if (e > 11'd1150) return {d[63], 8'hFF, 23'd0};
        e = e - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fop(input logic [31:0] a, input logic [31:0] b, input logic s);
        return r2sp(s ? (sp2r(a) - sp2r(b)) : (sp2r(a) + sp2r(b)));
    endfunction

    // Behavioural shared adder: combinational integer path, FL-stage float pipe with common enable.
    logic [FL-1:0] pipe_v;
    logic [31:0]   pipe_r [FL];
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            pipe_v <= '0;
        end else if (bus.add_enable) begin
            pipe_v[0] <= bus.add_in_valid && bus.add_is_float;
            pipe_r[0] <= fop(bus.add_in0, bus.add_in1, bus.add_is_sub);
            for (int i = 1; i < FL; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end
    always_comb begin
        if (bus.add_is_float) begin
            bus.add_out_valid  = pipe_v[FL-1] | inj;
            bus.add_out_result = pipe_r[FL-1];
        end else begin
            bus.add_out_valid  = bus.add_in_valid | inj;
            bus.add_out_result = bus.add_is_sub ? (bus.add_in0 - bus.add_in1) : (bus.add_in0 + bus.add_in1);
        end
    end

    // Reference model: in-flight float ops as a queue of {owner, result, age}.
    typedef struct { int id; logic [31:0] res; int age; } ent_t;
    ent_t m_q[$];
    int   m_rr;
    bit   m_mode, m_err;
    bit   e_head, e_en, e_issue, e_isf, e_busy, e_err;
    int   e_w;
    logic [N-1:0] e_ready, e_rsp;
    logic [31:0]  e_res;

    function automatic logic [31:0] opnd(input int w, input bit second);
        return second ? bus.req_input1[w*BW +: BW] : bus.req_input0[w*BW +: BW];
    endfunction

    task automatic model_eval();
        int w;
        w = -1;
        e_head = (m_q.size() > 0) && (m_q[0].age == FL - 1);
        e_en = 1'b1;
        if (e_head) e_en = bus.rsp_ready[m_q[0].id];
        for (int k = 0; k < N; k++) begin
            if (w < 0 && bus.req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
        end
        e_w = w;
        e_issue = 1'b0;
        if (w >= 0) e_issue = bus.req_is_float[w] ? e_en : (m_q.size() == 0 && bus.rsp_ready[w]);
        if (!rstnn) begin
            e_issue = 1'b0;
            e_en = 1'b1;
        end
        e_ready = e_issue ? N'(1 << w) : '0;
        e_rsp = '0;
        e_res = '0;
        if (rstnn && e_head) begin
            e_rsp = N'(1 << m_q[0].id);
            e_res = m_q[0].res;
        end else if (e_issue && !bus.req_is_float[w]) begin
            e_rsp = N'(1 << w);
            e_res = bus.req_is_sub[w] ? (opnd(w, 0) - opnd(w, 1)) : (opnd(w, 0) + opnd(w, 1));
        end
        e_isf  = rstnn && (e_issue ? bus.req_is_float[w] : m_mode);
        e_busy = rstnn && (m_q.size() != 0);
        e_err  = m_err;
    endtask

    task automatic model_update();
        ent_t n;
        if (!rstnn) begin
            m_q.delete();
            m_rr = 0; m_mode = 1'b0; m_err = 1'b0;
            return;
        end
        if (inj && e_isf && !e_head) m_err = 1'b1;
        if (e_en) begin
            foreach (m_q[i]) m_q[i].age = m_q[i].age + 1;
            if (m_q.size() > 0 && m_q[0].age == FL) void'(m_q.pop_front());
            if (e_issue && bus.req_is_float[e_w]) begin
                n.id = e_w; n.age = 0;
                n.res = fop(opnd(e_w, 0), opnd(e_w, 1), bus.req_is_sub[e_w]);
                m_q.push_back(n);
            end
        end
        if (e_issue) begin
            m_rr = (e_w + 1) % N;
            m_mode = bus.req_is_float[e_w];
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick_a();
        model_eval();
        @(negedge clk);
        chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp));
        if (e_rsp != '0) chk("rsp_result", bus.rsp_result, e_res);
        chk("add_enable", 32'(bus.add_enable), 32'(e_en));
        chk("add_in_valid", 32'(bus.add_in_valid), 32'(e_issue));
        chk("add_is_float", 32'(bus.add_is_float), 32'(e_isf));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("err_orphan", 32'(err_orphan), 32'(e_err));
    endtask

    task automatic tick_b();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic tick();
        tick_a();
        tick_b();
    endtask

    task automatic set_req(input int i, input logic v, input logic f, input logic s,
                           input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[i]    = v;
        bus.req_is_float[i] = f;
        bus.req_is_sub[i]   = s;
        bus.req_input0[i*BW +: BW] = a;
        bus.req_input1[i*BW +: BW] = b;
    endtask

    logic [31:0] fa [N] = '{32'h3FC00000, 32'h3F800000, 32'h40000000, 32'h40400000};
    logic [31:0] fb [N] = '{32'h40100000, 32'h3F800000, 32'h3F000000, 32'h3E800000};
    logic        fs [N] = '{1'b0, 1'b0, 1'b1, 1'b0};

    task automatic set_floats(input logic v);
        for (int i = 0; i < N; i++) set_req(i, v, 1'b1, fs[i], fa[i], fb[i]);
    endtask

    typedef struct {
        logic [3:0]  valid, rdy, sub, e_grant, e_rsp;
        logic [31:0] e_res;
    } vec_t;
    vec_t tbl [10];

    initial begin
        // Integer-only vectors starting from rr_ptr=0; operands are 100*(i+1) and i+3.
        tbl[0] = '{4'b1111, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 32'd103};
        tbl[1] = '{4'b1111, 4'b1111, 4'b0010, 4'b0010, 4'b0010, 32'd196};
        tbl[2] = '{4'b0001, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 32'd103};
        tbl[3] = '{4'b1000, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 32'd0};
        tbl[4] = '{4'b1000, 4'b1111, 4'b1000, 4'b1000, 4'b1000, 32'd394};
        tbl[5] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'd0};
        tbl[6] = '{4'b0110, 4'b1111, 4'b0100, 4'b0010, 4'b0010, 32'd204};
        tbl[7] = '{4'b0110, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 32'd0};
        tbl[8] = '{4'b0110, 4'b1111, 4'b0100, 4'b0100, 4'b0100, 32'd295};
        tbl[9] = '{4'b0011, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 32'd103};

        total = 0; bad = 0; cyc = 0;
        m_rr = 0; m_mode = 1'b0; m_err = 1'b0;
        rstnn = 1'b0; inj = 1'b0;
        bus.req_valid = '0; bus.req_is_sub = '0; bus.req_is_float = '0;
        bus.req_input0 = '0; bus.req_input1 = '0; bus.rsp_ready = '1;
        @(posedge clk); #1;

        // Reset state.
        tick_a();
        chk("rst_is_sub", 32'(bus.add_is_sub), 32'd0);
        chk("rst_in0", bus.add_in0, 32'd0);
        chk("rst_enable", 32'(bus.add_enable), 32'd1);
        tick_b();
        rstnn = 1'b1;

        // Table-driven integer arbitration.
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N; i++) set_req(i, tbl[k].valid[i], 1'b0, tbl[k].sub[i], 32'(100 * (i + 1)), 32'(i + 3));
            bus.rsp_ready = tbl[k].rdy;
            tick_a();
            chk("tbl_grant", 32'(bus.req_ready), 32'(tbl[k].e_grant));
            chk("tbl_rsp", 32'(bus.rsp_valid), 32'(tbl[k].e_rsp));
            if (tbl[k].e_rsp != 4'd0) chk("tbl_result", bus.rsp_result, tbl[k].e_res);
            tick_b();
        end
        bus.req_valid = '0; bus.rsp_ready = '1;

        // Continuous float stream from a fresh rr_ptr.
        rstnn = 1'b0; tick(); rstnn = 1'b1;
        set_floats(1'b1);
        for (int k = 0; k < 8; k++) begin
            tick_a();
            chk("stream_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
            if (k >= 3) chk("stream_rsp", 32'(bus.rsp_valid), 32'(1 << ((k - 3) % 4)));
            if (k == 3) chk("stream_sum", bus.rsp_result, 32'h40700000);
            tick_b();
        end
        set_floats(1'b0);
        for (int k = 0; k < 4; k++) tick();

        // Integer request stuck behind an in-flight float.
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h3F800000, 32'h3F800000);
        tick();
        set_req(1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        set_req(2, 1'b1, 1'b0, 1'b1, 32'd7, 32'd3);
        for (int t = 1; t <= 4; t++) begin
            tick_a();
            if (t < 4) chk("int_wait_grant", 32'(bus.req_ready), 32'd0);
            if (t == 3) chk("float_before_int", 32'(bus.rsp_valid), 32'b0010);
            if (t == 4) begin
                chk("int_grant", 32'(bus.req_ready), 32'b0100);
                chk("int_rsp", 32'(bus.rsp_valid), 32'b0100);
                chk("int_result", bus.rsp_result, 32'd4);
            end
            tick_b();
        end
        set_req(2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Response backpressure freezes the float pipe.
        set_floats(1'b1);
        for (int k = 0; k < 3; k++) tick();
        bus.rsp_ready = '0;
        for (int k = 0; k < 5; k++) begin
            tick_a();
            chk("stall_enable", 32'(bus.add_enable), 32'd0);
            chk("stall_grant", 32'(bus.req_ready), 32'd0);
            tick_b();
        end
        bus.rsp_ready = '1;
        for (int k = 0; k < 4; k++) tick();
        set_floats(1'b0);
        for (int k = 0; k < 5; k++) tick();

        // Integer request whose own response port is not ready.
        set_req(0, 1'b1, 1'b0, 1'b0, 32'd10, 32'd20);
        bus.rsp_ready = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            tick_a();
            chk("own_rdy_grant", 32'(bus.req_ready), 32'd0);
            chk("own_rdy_inv", 32'(bus.add_in_valid), 32'd0);
            tick_b();
        end
        bus.rsp_ready = '1;
        tick_a();
        chk("own_rdy_go", 32'(bus.req_ready), 32'b0001);
        chk("own_rdy_res", bus.rsp_result, 32'd30);
        tick_b();
        set_req(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset with three floats in flight.
        set_floats(1'b1);
        for (int k = 0; k < 3; k++) tick();
        set_floats(1'b0);
        rstnn = 1'b0; tick(); rstnn = 1'b1;
        for (int k = 0; k < FL + 1; k++) begin
            tick_a();
            chk("post_rst_busy", 32'(busy), 32'd0);
            chk("post_rst_rsp", 32'(bus.rsp_valid), 32'd0);
            tick_b();
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, 32'(i), 32'd1);
        tick_a();
        chk("post_rst_first", 32'(bus.req_ready), 32'b0001);
        tick_b();
        bus.req_valid = '0;

        // Orphan result in float mode with no tag at the head.
        set_req(0, 1'b1, 1'b1, 1'b0, fa[0], fb[0]);
        tick();
        set_req(0, 1'b0, 1'b1, 1'b0, fa[0], fb[0]);
        for (int k = 0; k < FL + 1; k++) tick();
        inj = 1'b1;
        tick_a();
        chk("orphan_mode", 32'(bus.add_is_float), 32'd1);
        tick_b();
        inj = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick_a();
            chk("orphan_sticky", 32'(err_orphan), 32'd1);
            tick_b();
        end
        rstnn = 1'b0; tick(); rstnn = 1'b1;
        tick_a();
        chk("orphan_cleared", 32'(err_orphan), 32'd0);
        tick_b();

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic f;
            rstnn = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < N; i++) begin
                f = 1'($urandom_range(0, 1));
                if (f) set_req(i, $urandom_range(0, 2) != 0, 1'b1, 1'($urandom_range(0, 1)),
                               {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)},
                               {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)});
                else   set_req(i, $urandom_range(0, 2) != 0, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
                bus.rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        rstnn = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
